// File: rtl/lcd_write_controller_pkg.sv
// Shared definitions for the LCD write controller: word layout, opcodes,
// controller states and the pixel format conversion.
package lcd_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LCD_W     = 16;
    localparam int unsigned PAYLOAD_W = 24;

    localparam logic [7:0] OP_CMD   = 8'h00;
    localparam logic [7:0] OP_DATA  = 8'h01;
    localparam logic [7:0] OP_PIXEL = 8'h02;
    localparam logic [7:0] OP_DELAY = 8'h03;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WR_LOW  = 3'd2,
        WR_HIGH = 3'd3,
        DELAY   = 3'd4
    } state_t;

    function automatic logic [LCD_W-1:0] rgb888_to_rgb565(input logic [PAYLOAD_W-1:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/lcd_write_controller_if.sv
// FIFO read side and 8080 write bus of the LCD write controller, bundled so the
// controller (slave) and its environment (master) share one connection.
interface lcd_write_controller_if;
    import lcd_pkg::*;

    logic [WORD_W-1:0] i_fifoData;
    logic              i_fifoEmpty;
    logic              o_fifoRead;
    logic [LCD_W-1:0]  o_lcdData;
    logic              o_lcdDc;
    logic              o_lcdWrN;
    logic              o_lcdCsN;
    logic              o_busy;

    modport master (
        output i_fifoData, i_fifoEmpty,
        input  o_fifoRead, o_lcdData, o_lcdDc, o_lcdWrN, o_lcdCsN, o_busy
    );

    modport slave (
        input  i_fifoData, i_fifoEmpty,
        output o_fifoRead, o_lcdData, o_lcdDc, o_lcdWrN, o_lcdCsN, o_busy
    );

endinterface

// File: rtl/lcd_write_controller.sv
// Pops command words from a show-ahead FIFO and plays them out on an 8080-style
// 16-bit write bus; one shared counter times both the WR strobe and DELAY words.
module lcd_write_controller
    import lcd_pkg::*;
#(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2
) (
    input  logic                   i_clock,
    input  logic                   i_nReset,
    lcd_write_controller_if.slave  bus
);

    localparam logic [PAYLOAD_W-1:0] LOW_LOAD  = PAYLOAD_W'(WR_LOW_CYCLES - 1);
    localparam logic [PAYLOAD_W-1:0] HIGH_LOAD = PAYLOAD_W'(WR_HIGH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] cnt_q, cnt_d;
    logic [LCD_W-1:0]     data_q, data_d;
    logic                 dc_q, dc_d;
    logic                 wrn_q, wrn_d;
    logic                 csn_q, csn_d;
    logic                 busy_q, busy_d;

    logic                 pop;
    logic [7:0]           opcode;
    logic [PAYLOAD_W-1:0] payload;

    assign opcode  = bus.i_fifoData[31:24];
    assign payload = bus.i_fifoData[23:0];
    // Reset masks the pop so a word is never lost to a cycle the FSM ignores.
    assign pop     = (state_q == IDLE) && !bus.i_fifoEmpty && i_nReset;

    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            wrn_q   <= 1'b1;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            wrn_q   <= wrn_d;
            csn_q   <= csn_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (opcode == OP_CMD || opcode == OP_DATA || opcode == OP_PIXEL) begin
                        state_d = SETUP;
                    end else if (opcode == OP_DELAY && payload != '0) begin
                        state_d = DELAY;
                        cnt_d   = payload - 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = WR_LOW;
                cnt_d   = LOW_LOAD;
            end
            WR_LOW: begin
                if (cnt_q == '0) begin
                    state_d = WR_HIGH;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HIGH, DELAY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered copies of what the next state requires.
    always_comb begin
        data_d = data_q;
        dc_d   = dc_q;
        if (pop) begin
            if (opcode == OP_CMD) begin
                data_d = payload[15:0];
                dc_d   = 1'b0;
            end else if (opcode == OP_DATA) begin
                data_d = payload[15:0];
                dc_d   = 1'b1;
            end else if (opcode == OP_PIXEL) begin
                data_d = rgb888_to_rgb565(payload);
                dc_d   = 1'b1;
            end
        end
        wrn_d  = (state_d != WR_LOW);
        csn_d  = !(state_d == SETUP || state_d == WR_LOW || state_d == WR_HIGH);
        busy_d = (state_d != IDLE);
    end

    assign bus.o_fifoRead = pop;
    assign bus.o_lcdData  = data_q;
    assign bus.o_lcdDc    = dc_q;
    assign bus.o_lcdWrN   = wrn_q;
    assign bus.o_lcdCsN   = csn_q;
    assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_lcd_write_controller.sv
// Bench for lcd_write_controller: single-word table, directed corner sequences and
// randomized word streams against a cycle-budget transaction model.
module tb_lcd_write_controller;

    localparam int L    = 2;
    localparam int H    = 2;
    localparam int MAXC = 6000;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic        dc;
    } rise_t;

    typedef struct {
        logic [31:0] w;
        logic [15:0] d;
        logic        dc;
        int          nrise;
        int          busy_cyc;
    } vec_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    lcd_write_controller_if lif();

    lcd_write_controller #(
        .WR_LOW_CYCLES (L),
        .WR_HIGH_CYCLES(H)
    ) dut (
        .i_clock (clk),
        .i_nReset(nrst),
        .bus     (lif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] wq[$];
    logic [31:0] words[$];
    bit          stall[MAXC];
    int          pop_act[$];
    rise_t       rise_act[$];
    bit          busy_act[MAXC], csl_act[MAXC], wrl_act[MAXC];
    int          empty_pops;
    int          pop_exp[$];
    rise_t       rise_exp[$];
    bit          busy_exp[MAXC], csl_exp[MAXC], wrl_exp[MAXC];
    vec_t        tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int occ_of(input logic [31:0] w);
        if (w[31:24] <= 8'd2) return 2 + L + H;
        if (w[31:24] == 8'd3) return 1 + int'(w[23:0]);
        return 1;
    endfunction

    function automatic logic [15:0] exp_data(input logic [31:0] w);
        int r, g, b;
        if (w[31:24] != 8'd2) return w[15:0];
        r = int'(w[23:16]);
        g = int'(w[15:8]);
        b = int'(w[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // Each word starts at the first non-stalled cycle once the previous one is finished.
    task automatic model(output int endc);
        int t;
        int o;
        pop_exp.delete();
        rise_exp.delete();
        for (int i = 0; i < MAXC; i++) begin
            busy_exp[i] = 0; csl_exp[i] = 0; wrl_exp[i] = 0;
        end
        t = 0;
        foreach (words[k]) begin
            while (stall[t]) t++;
            pop_exp.push_back(t);
            o = occ_of(words[k]);
            for (int i = t + 1; i < t + o; i++) busy_exp[i] = 1;
            if (words[k][31:24] <= 8'd2) begin
                for (int i = t + 1; i <= t + 1 + L + H; i++) csl_exp[i] = 1;
                for (int i = t + 2; i <= t + 1 + L; i++) wrl_exp[i] = 1;
                rise_exp.push_back('{t + 2 + L, exp_data(words[k]), words[k][31:24] != 8'd0});
            end
            t = t + o;
        end
        endc = t + 8;
    endtask

    task automatic run(input int ncyc);
        bit rd;
        pop_act.delete();
        rise_act.delete();
        empty_pops = 0;
        for (int c = 0; c < ncyc; c++) begin
            lif.i_fifoEmpty = (wq.size() == 0) || stall[c];
            lif.i_fifoData  = (wq.size() != 0) ? wq[0] : $urandom();
            @(negedge clk);
            busy_act[c] = lif.o_busy;
            csl_act[c]  = !lif.o_lcdCsN;
            wrl_act[c]  = !lif.o_lcdWrN;
            rd = lif.o_fifoRead;
            if (rd) begin
                pop_act.push_back(c);
                if (lif.i_fifoEmpty) empty_pops++;
            end
            if (c > 0) begin
                if (wrl_act[c-1] && !wrl_act[c]) rise_act.push_back('{c, lif.o_lcdData, lif.o_lcdDc});
            end
            @(posedge clk);
            if (rd && wq.size() != 0) void'(wq.pop_front());
            #1;
        end
    endtask

    task automatic compare(input string tag, input int ncyc);
        int mb, mc, mw;
        check($sformatf("%s/pop_count", tag), pop_act.size(), pop_exp.size());
        for (int i = 0; i < pop_act.size() && i < pop_exp.size(); i++)
            check($sformatf("%s/pop_cycle[%0d]", tag, i), pop_act[i], pop_exp[i]);
        check($sformatf("%s/rise_count", tag), rise_act.size(), rise_exp.size());
        for (int i = 0; i < rise_act.size() && i < rise_exp.size(); i++) begin
            check($sformatf("%s/rise_cycle[%0d]", tag, i), rise_act[i].cyc, rise_exp[i].cyc);
            check($sformatf("%s/rise_data[%0d]", tag, i), 32'(rise_act[i].d), 32'(rise_exp[i].d));
            check($sformatf("%s/rise_dc[%0d]", tag, i), 32'(rise_act[i].dc), 32'(rise_exp[i].dc));
        end
        mb = 0; mc = 0; mw = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (busy_act[c] != busy_exp[c]) mb++;
            if (csl_act[c] != csl_exp[c]) mc++;
            if (wrl_act[c] != wrl_exp[c]) mw++;
        end
        check($sformatf("%s/busy_trace_mismatches", tag), mb, 0);
        check($sformatf("%s/cs_trace_mismatches", tag), mc, 0);
        check($sformatf("%s/wr_trace_mismatches", tag), mw, 0);
        check($sformatf("%s/pops_while_empty", tag), empty_pops, 0);
    endtask

    task automatic stream(input string tag, output int ncyc);
        wq = words;
        model(ncyc);
        run(ncyc);
        compare(tag, ncyc);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        lif.i_fifoEmpty = 1'b0;
        lif.i_fifoData  = 32'h0000_002A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/fifoRead", 32'(lif.o_fifoRead), 32'd0);
        check("reset/wrN", 32'(lif.o_lcdWrN), 32'd1);
        check("reset/csN", 32'(lif.o_lcdCsN), 32'd1);
        check("reset/busy", 32'(lif.o_busy), 32'd0);
        check("reset/data_dc", {15'd0, lif.o_lcdDc, lif.o_lcdData}, 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic clear_stall();
        for (int i = 0; i < MAXC; i++) stall[i] = 0;
    endtask

    initial begin
        int n;
        int cnt;
        lif.i_fifoEmpty = 1'b1;
        lif.i_fifoData  = '0;
        clear_stall();

        tbl[0] = '{32'h0000_002A, 16'h002A, 1'b0, 1, 5};
        tbl[1] = '{32'h0100_1234, 16'h1234, 1'b1, 1, 5};
        tbl[2] = '{32'h02FF_8040, 16'hFC08, 1'b1, 1, 5};
        tbl[3] = '{32'h0212_3456, 16'h11AA, 1'b1, 1, 5};
        tbl[4] = '{32'h0300_0005, 16'h0000, 1'b0, 0, 5};
        tbl[5] = '{32'h0300_0000, 16'h0000, 1'b0, 0, 0};
        tbl[6] = '{32'h7F12_3456, 16'h0000, 1'b0, 0, 0};
        tbl[7] = '{32'h04AB_CDEF, 16'h0000, 1'b0, 0, 0};

        // Idle with an empty FIFO.
        do_reset();
        words = {};
        wq = {};
        run(20);
        cnt = 0;
        for (int c = 0; c < 20; c++) cnt += int'(busy_act[c]) + int'(csl_act[c]) + int'(wrl_act[c]);
        check("empty/pops", pop_act.size(), 0);
        check("empty/activity_cycles", cnt, 0);

        // Single words, constant expectations.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            words = {tbl[i].w};
            stream($sformatf("tbl%0d", i), n);
            check($sformatf("tbl%0d/nrise", i), rise_act.size(), tbl[i].nrise);
            if (rise_act.size() > 0) begin
                check($sformatf("tbl%0d/data", i), 32'(rise_act[0].d), 32'(tbl[i].d));
                check($sformatf("tbl%0d/dc", i), 32'(rise_act[0].dc), 32'(tbl[i].dc));
            end
            cnt = 0;
            for (int c = 0; c < n; c++) cnt += int'(busy_act[c]);
            check($sformatf("tbl%0d/busy_cycles", i), cnt, tbl[i].busy_cyc);
        end

        // Back-to-back pixel burst.
        do_reset();
        words = {};
        for (int i = 0; i < 4; i++) words.push_back({8'h02, 24'($urandom())});
        stream("burst", n);
        for (int i = 1; i < rise_act.size(); i++)
            check($sformatf("burst/rise_spacing[%0d]", i), rise_act[i].cyc - rise_act[i-1].cyc, 6);

        // 100-cycle delay, then a command.
        do_reset();
        words = {32'h0300_0064, 32'h0000_00C3};
        stream("delay100", n);
        cnt = 0;
        for (int c = 0; c <= 100; c++) cnt += int'(csl_act[c]) + int'(wrl_act[c]);
        check("delay100/bus_activity", cnt, 0);
        if (rise_act.size() > 0) check("delay100/cmd_rise_cycle", rise_act[0].cyc, 105);
        else check("delay100/cmd_rise_present", 0, 1);

        // Zero-length delay, then a command.
        do_reset();
        words = {32'h0300_0000, 32'h0000_0011};
        stream("delay0", n);
        if (pop_act.size() > 1) check("delay0/second_pop_cycle", pop_act[1], 1);
        else check("delay0/second_pop_present", pop_act.size(), 2);

        // Reset in the middle of WR_LOW.
        do_reset();
        lif.i_fifoEmpty = 1'b0;
        lif.i_fifoData  = 32'h0000_0055;
        @(negedge clk);
        check("midrst/pop", 32'(lif.o_fifoRead), 32'd1);
        @(posedge clk);
        #1 lif.i_fifoData = 32'h0000_00AA;
        @(negedge clk);
        check("midrst/setup_cs", 32'(lif.o_lcdCsN), 32'd0);
        check("midrst/setup_no_pop", 32'(lif.o_fifoRead), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
        check("midrst/wr_low", 32'(lif.o_lcdWrN), 32'd0);
        check("midrst/pop_masked", 32'(lif.o_fifoRead), 32'd0);
        @(posedge clk);
        #1;
        check("midrst/wrN", 32'(lif.o_lcdWrN), 32'd1);
        check("midrst/csN", 32'(lif.o_lcdCsN), 32'd1);
        check("midrst/data", 32'(lif.o_lcdData), 32'd0);
        check("midrst/busy", 32'(lif.o_busy), 32'd0);
        nrst = 1'b1;
        words = {32'h0000_00AA};
        stream("after_rst", n);

        // Random streams, without and with FIFO stalls.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            clear_stall();
            if (pass == 1)
                for (int i = 0; i < MAXC; i++) stall[i] = ($urandom_range(0, 3) == 0);
            words = {};
            for (int i = 0; i < 60; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 3)       words.push_back({8'h00, 24'($urandom())});
                else if (r < 5)  words.push_back({8'h01, 24'($urandom())});
                else if (r < 8)  words.push_back({8'h02, 24'($urandom())});
                else if (r == 8) words.push_back({8'h03, 24'($urandom_range(0, 20))});
                else             words.push_back({8'($urandom_range(4, 255)), 24'($urandom())});
            end
            stream($sformatf("rand%0d", pass), n);
        end
        clear_stall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_write_controller.md
# lcd_write_controller

Consumes 32-bit command words from the show-ahead LCD FIFO and drives an 8080-style 16-bit parallel LCD write bus (CS, D/C, WR, data). Each word carries an opcode: register command, raw data, RGB888 pixel (converted to RGB565) or a timed delay. It sits directly downstream of the LCD FIFO, in the LCD clock domain, and paces the bus with programmable WR low/high widths.

## Interface
- WR_LOW_CYCLES, 2, cycles o_lcdWrN is held low per transfer (≥1)
- WR_HIGH_CYCLES, 2, cycles o_lcdWrN is held high after the rising edge before the transfer ends (≥1)
- i_clock  in  1  LCD clock; all logic on rising edge
- i_nReset  in  1  synchronous, active-low reset
- i_fifoData  in  32  head-of-FIFO word; valid whenever i_fifoEmpty=0
- i_fifoEmpty  in  1  FIFO empty flag
- o_fifoRead  out  1  pop strobe; FIFO advances at the edge where this is 1
- o_lcdData  out  16  LCD data bus
- o_lcdDc  out  1  0 = command, 1 = data
- o_lcdWrN  out  1  write strobe, active low; LCD latches on its rising edge
- o_lcdCsN  out  1  chip select, active low
- o_busy  out  1  1 whenever state ≠ IDLE

## Operation
- Word format: [31:24] opcode, [23:0] payload.
- 0x00 CMD: o_lcdData=payload[15:0], o_lcdDc=0. 0x01 DATA: payload[15:0], o_lcdDc=1. 0x02 PIXEL: o_lcdData={payload[23:19], payload[15:10], payload[7:3]}, o_lcdDc=1. 0x03 DELAY: no bus activity for payload cycles. Any other opcode: word popped and discarded, no bus activity.
- States: IDLE, SETUP, WR_LOW, WR_HIGH, DELAY.
- IDLE: o_fifoRead = (state==IDLE && !i_fifoEmpty), combinational. Same edge: capture i_fifoData; CMD/DATA/PIXEL → SETUP; DELAY with payload≠0 → DELAY, payload=0 → IDLE; unknown → IDLE.
- SETUP (1 cycle): o_lcdCsN=0, o_lcdData/o_lcdDc driven from captured word, o_lcdWrN=1 → WR_LOW.
- WR_LOW: o_lcdWrN=0 for WR_LOW_CYCLES → WR_HIGH.
- WR_HIGH: o_lcdWrN=1 for WR_HIGH_CYCLES; data, D/C and CS held stable → IDLE.
- DELAY: 24-bit down-counter loaded with payload; → IDLE after exactly payload cycles in DELAY.
- o_lcdCsN=1 in IDLE and DELAY; o_lcdData/o_lcdDc hold their last value outside transfers.
- Reset values: o_lcdWrN=1, o_lcdCsN=1, o_lcdDc=0, o_lcdData=0, o_busy=0, o_fifoRead=0, state IDLE, counters 0.

## Timing
- Bus/status outputs registered; only o_fifoRead is combinational.
- Bus transfer occupancy: 1 (IDLE/pop) + 1 + WR_LOW_CYCLES + WR_HIGH_CYCLES cycles; defaults → 6 cycles/word, back-to-back.
- o_lcdWrN falls 1 cycle after CS falls; data stable ≥1 cycle before WR falls and WR_HIGH_CYCLES after WR rises.
- DELAY word occupancy: 1 + payload cycles. Unknown word: 1 cycle.
- Empty FIFO: stay in IDLE, o_fifoRead=0; no pop ever issued when i_fifoEmpty=1.
- Reset asserted mid-transfer: at that edge all outputs to reset values, in-flight word lost (already popped); no WR rising edge is generated by reset other than returning WR high.
- Reset has priority over every transition including a same-cycle pop (o_fifoRead forced 0 while i_nReset=0).
- DELAY counter is 24 bits; payload 0xFFFFFF must complete without wrap.

## Structure
- Package lcd_pkg: opcode constants (OP_CMD, OP_DATA, OP_PIXEL, OP_DELAY), state enum, rgb888→rgb565 function.
- Single module; strobe width and delay share one counter, no sub-module.

## Test plan
- Reset, FIFO empty → o_lcdWrN=1, o_lcdCsN=1, o_busy=0, o_fifoRead never 1 for 20 cycles.
- Word 0x0000002A → one pop, o_lcdDc=0, o_lcdData=0x002A, WR low 2 cycles, CS low 5 cycles, next pop no earlier than 6 cycles later.
- Word 0x02FF8040 → o_lcdDc=1, o_lcdData=0xFC08; burst of 4 PIXEL words → 4 WR rising edges exactly 6 cycles apart.
- Word 0x03000064 followed by CMD → no CS/WR activity for 100 cycles, then CMD transfer starts; payload 0 → next pop 1 cycle later.
- Word 0x7F123456 → popped, no WR/CS activity, o_busy 0 next cycle.
- i_nReset low during WR_LOW → o_lcdWrN=1, o_lcdCsN=1, o_lcdData=0 next edge; after release, next FIFO word transferred normally.
